// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the bus signals that meet at the memory arbiter.
//   cpu_*  : 6502 core bus (address, write data/strobe, read data, rdy stall)
//   dma_*  : DMA requester (req/gnt handshake, beat address/data, read valid)
//   mem_*  : single synchronous-write / asynchronous-read memory port
// Modports:
//   slave  : the arbiter itself
//   master : the surroundings (core, DMA engine and memory model)
interface mem_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rdy;

  logic        dma_req;
  logic [15:0] dma_address;
  logic [7:0]  dma_wr_data;
  logic        dma_wr_enable;
  logic        dma_gnt;
  logic [7:0]  dma_rd_data;
  logic        dma_rd_valid;

  logic [15:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_enable;
  logic [7:0]  mem_rd_data;

  modport slave (
    input  cpu_address, cpu_wr_data, cpu_wr_enable,
    input  dma_req, dma_address, dma_wr_data, dma_wr_enable,
    input  mem_rd_data,
    output cpu_rd_data, cpu_rdy,
    output dma_gnt, dma_rd_data, dma_rd_valid,
    output mem_address, mem_wr_data, mem_wr_enable
  );

  modport master (
    output cpu_address, cpu_wr_data, cpu_wr_enable,
    output dma_req, dma_address, dma_wr_data, dma_wr_enable,
    output mem_rd_data,
    input  cpu_rd_data, cpu_rdy,
    input  dma_gnt, dma_rd_data, dma_rd_valid,
    input  mem_address, mem_wr_data, mem_wr_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the 6502 core and a DMA engine.
// The core owns the bus by default; DMA is granted after dma_req has been
// pending MAX_WAIT cycles and keeps the bus for at most BURST_LEN beats,
// during which the core is stalled via cpu_rdy.
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : mem_arbiter_if.slave (cpu_*, dma_*, mem_* groups)
module mem_arbiter #(
  parameter int MAX_WAIT  = 8,  // 1..255
  parameter int BURST_LEN = 4   // 1..16
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } own_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);

  own_e       state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  logic dma_beat;
  assign dma_beat = (state_q == OWN_DMA) && bus.dma_req;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      OWN_CPU: begin
        if (!bus.dma_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = OWN_DMA;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
        end else begin
          // Equality above catches WAIT_LAST first, so this never wraps.
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      OWN_DMA: begin
        if (!bus.dma_req) begin
          // Idle cycle: requester withdrew, hand back on this edge.
          state_d    = OWN_CPU;
          wait_cnt_d = '0;
        end else if (beat_cnt_q == BEAT_LAST) begin
          state_d    = OWN_CPU;
          wait_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end

      default: state_d = OWN_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OWN_CPU;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Memory port is a pure mux on the state register, so ownership cannot
  // change mid-cycle; reset reaches the outputs through state_q directly.
  assign bus.cpu_rdy      = (state_q == OWN_CPU);
  assign bus.dma_gnt      = dma_beat;
  assign bus.dma_rd_valid = dma_beat && !bus.dma_wr_enable;

  assign bus.mem_address  = (state_q == OWN_DMA) ? bus.dma_address : bus.cpu_address;
  assign bus.mem_wr_data  = (state_q == OWN_DMA) ? bus.dma_wr_data : bus.cpu_wr_data;

  // A stalled CPU write is dropped here and re-presented by the core after
  // handback; reset forces the strobe low regardless of the cpu inputs.
  assign bus.mem_wr_enable = !reset &&
                             ((state_q == OWN_CPU) ? bus.cpu_wr_enable
                                                   : (dma_beat && bus.dma_wr_enable));

  assign bus.cpu_rd_data  = bus.mem_rd_data;
  assign bus.dma_rd_data  = bus.mem_rd_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single processor memory bus between the 6502 core (`proc`) and a DMA requester, such as a video or block-copy engine. The core owns the bus by default and is stalled through `cpu_rdy` whenever the DMA engine is granted. A wait limit bounds how long DMA can be starved, and a burst limit bounds how long the CPU can be stalled. The block sits between `proc` and the synchronous RAM/ROM (asynchronous-read) model.

## Interface
Parameters:
- `MAX_WAIT`, default 8: cycles `dma_req` must be pending before a forced grant, and the minimum number of CPU cycles between grants. Legal range 1..255.
- `BURST_LEN`, default 4: maximum DMA beats per grant. Legal range 1..16.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cpu_address`  in  16: core bus address.
- `cpu_wr_data`  in  8: core write data.
- `cpu_wr_enable`  in  1: core write strobe.
- `cpu_rd_data`  out  8: read data to core. Equals `mem_rd_data`; meaningful only while `cpu_rdy`=1.
- `cpu_rdy`  out  1: 1 means the core's current bus cycle completes; 0 means the core holds all outputs and state.
- `dma_req`  in  1: DMA wants a beat. Held high while more beats are wanted.
- `dma_address`  in  16: DMA beat address.
- `dma_wr_data`  in  8: DMA beat write data.
- `dma_wr_enable`  in  1: DMA beat is a write.
- `dma_gnt`  out  1: the current cycle is a DMA beat.
- `dma_rd_data`  out  8: equals `mem_rd_data`.
- `dma_rd_valid`  out  1: `dma_gnt & ~dma_wr_enable`.
- `mem_address`  out  16: memory address.
- `mem_wr_data`  out  8: memory write data.
- `mem_wr_enable`  out  1: memory write strobe.
- `mem_rd_data`  in  8: asynchronous read data for `mem_address`.

## Operation
- Two-state FSM, registered: `OWN_CPU` (reset state) and `OWN_DMA`. Counters: `wait_cnt` (8 bit) and `beat_cnt` (4 bit).
- `OWN_CPU`:
  - Memory port muxes the `cpu_*` inputs; `cpu_rdy`=1; `dma_gnt`=0.
  - Each edge with `dma_req`=1 increments `wait_cnt`; an edge with `dma_req`=0 clears it.
  - Edge with `dma_req`=1 and `wait_cnt`==`MAX_WAIT`-1 → `OWN_DMA`, clear `beat_cnt`.
- `OWN_DMA`:
  - `cpu_rdy`=0; the `cpu_*` inputs are ignored. A CPU write pending here is not propagated and completes after handback.
  - If `dma_req`=1: `dma_gnt`=1 and the memory port muxes the `dma_*` inputs. Each such edge is one beat: `beat_cnt`++.
  - Edge where a beat completes with `beat_cnt`==`BURST_LEN`-1 → `OWN_CPU`.
  - If `dma_req`=0: idle cycle (`dma_gnt`=0, `mem_wr_enable`=0, `cpu_rdy`=0). The next edge goes → `OWN_CPU`.
  - Any transition into `OWN_CPU` clears `wait_cnt`.
- The memory port is a pure combinational mux selected by the state register. Ownership never changes within a cycle.
- Counters never wrap: `wait_cnt` saturates at `MAX_WAIT`-1 and `beat_cnt` at `BURST_LEN`-1.

## Timing
- Reset (asynchronous, while `reset`=1): state `OWN_CPU`, both counters 0, `cpu_rdy`=1, `dma_gnt`=0, `dma_rd_valid`=0, `mem_wr_enable`=0 (forced). `mem_address` and `mem_wr_data` follow the `cpu_*` inputs.
- Reset asserted mid-burst: `dma_gnt` drops and `cpu_rdy` rises asynchronously. The burst is abandoned and not resumed.
- Grant latency: cycle 0 is the first cycle with `dma_req`=1 (held). DMA owns cycles `MAX_WAIT`..`MAX_WAIT`+`BURST_LEN`-1, and the CPU resumes the next cycle.
- The next forced grant comes no earlier than `MAX_WAIT` CPU cycles after handback.
- `MAX_WAIT`=1: grant on the cycle after the first sampled request.
- Simultaneous `cpu_wr_enable` and a DMA beat: only the DMA write or read reaches memory.
- `dma_req` falling on the same edge as the final beat: the normal handback applies, with no idle cycle.

## Test plan
- Reset with `dma_req`=1 and `cpu_wr_enable`=1: `cpu_rdy`=1, `dma_gnt`=0, `mem_wr_enable`=0. After release, `mem_address` tracks `cpu_address`=16'hFFFC.
- Defaults (`MAX_WAIT`=8, `BURST_LEN`=4), `dma_req` held from cycle 0:
  - `dma_gnt`=1 and `cpu_rdy`=0 on cycles 8–11, with `mem_address`=`dma_address`.
  - `cpu_rdy`=1 on cycles 12–19.
  - Next grant on cycle 20.
- DMA write on a grant cycle (`dma_address`=16'h0200, `dma_wr_data`=8'hA5, `cpu_wr_enable`=1 with `cpu_address`=16'h0300): memory 0x0200=8'hA5 and 0x0300 unchanged. The CPU write lands at 0x0300 on the first cycle with `cpu_rdy`=1.
- DMA read of 0x1234 holding 8'h5C: `dma_rd_valid`=1 and `dma_rd_data`=8'h5C in the grant cycle.
- Early drop: `dma_req` low after 2 beats → one idle cycle (`dma_gnt`=0, `cpu_rdy`=0, `mem_wr_enable`=0), then `cpu_rdy`=1.
- Withdrawal: `dma_req` high for cycles 0–4, low at 5, high again at 6 → no grant until cycle 14.
- Reset pulse during beat 2 → `dma_gnt` falls without waiting for an edge. After release: `OWN_CPU`, and the full `MAX_WAIT` elapses before the next grant.
